// File: rtl/euclid_pkg.sv
// Shared constants, controller state encoding and counter helper for the
// RS(255,239) Euclidean key-equation solver.
package euclid_pkg;

  localparam int T        = 8;
  localparam int T2       = 2 * T;
  localparam int DEG_W    = 6;
  localparam int CNT_W    = 5;
  localparam int MAX_ITER = T2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/euclid_ctrl_if.sv
// Job handshake and datapath control bundle between euclid_ctrl (master)
// and its surroundings: syndrome stage, degree datapath, Chien/Forney stage.
interface euclid_ctrl_if;
  import euclid_pkg::*;

  logic             syn_valid;
  logic             syn_ready;
  logic             load;
  logic             run;
  logic             stop_i;
  logic             sw_i;
  logic [CNT_W-1:0] iter_cnt;
  logic [CNT_W-1:0] swap_cnt;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  modport master (
    input  syn_valid, stop_i, sw_i, out_ready,
    output syn_ready, load, run, iter_cnt, swap_cnt, out_valid, err
  );

  modport slave (
    output syn_valid, stop_i, sw_i, out_ready,
    input  syn_ready, load, run, iter_cnt, swap_cnt, out_valid, err
  );

endinterface

// File: rtl/euclid_iter_cnt.sv
// Saturating counter with synchronous clear and enable, plus an equality
// compare against a limit value taken from the registered count.
module euclid_iter_cnt
  import euclid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt      = cnt_r;
  assign at_limit = (cnt_r == limit);

endmodule

// File: rtl/euclid_ctrl.sv
// Euclidean key-equation solver sequencer: IDLE->LOAD->RUN->DRAIN->DONE.
// Define EUCLID_CTRL_TIMEOUT_EN to enable the MAX_ITER watchdog (sets err).
module euclid_ctrl
  import euclid_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  euclid_ctrl_if.master bus
);

  ctrl_state_e      state_r;
  ctrl_state_e      state_nxt_s;
  logic             clr_s;
  logic             iter_en_s;
  logic             swap_en_s;
  logic             err_set_s;
  logic             wd_en_s;
  logic             iter_lim_s;
  logic             swap_lim_unused_s;
  logic [CNT_W-1:0] iter_cnt_s;
  logic [CNT_W-1:0] swap_cnt_s;

  logic syn_ready_r;
  logic load_r;
  logic run_r;
  logic out_valid_r;
  logic err_r;

`ifdef EUCLID_CTRL_TIMEOUT_EN
  assign wd_en_s = 1'b1;
`else
  assign wd_en_s = 1'b0;
`endif

  // Next-state and counter control decode.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    iter_en_s   = 1'b0;
    swap_en_s   = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.syn_valid) begin
          state_nxt_s = LOAD;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD:  state_nxt_s = RUN;
      RUN: begin
        // Stop outranks the watchdog; the exit cycle never counts.
        if (bus.stop_i) begin
          state_nxt_s = DRAIN;
        end else if (wd_en_s && iter_lim_s) begin
          state_nxt_s = DRAIN;
          err_set_s   = 1'b1;
        end else begin
          iter_en_s = 1'b1;
          swap_en_s = bus.sw_i;
        end
      end
      DRAIN: state_nxt_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output flops decoded from next state so they align with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syn_ready_r <= 1'b1;
      load_r      <= 1'b0;
      run_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      syn_ready_r <= (state_nxt_s == IDLE);
      load_r      <= (state_nxt_s == LOAD);
      run_r       <= (state_nxt_s == RUN);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Watchdog error flag, held until the next job is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (clr_s) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  euclid_iter_cnt u_iter_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (clr_s),
    .en       (iter_en_s),
    .limit    (CNT_W'(MAX_ITER)),
    .cnt      (iter_cnt_s),
    .at_limit (iter_lim_s)
  );

  euclid_iter_cnt u_swap_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (clr_s),
    .en       (swap_en_s),
    .limit    ({CNT_W{1'b1}}),
    .cnt      (swap_cnt_s),
    .at_limit (swap_lim_unused_s)
  );

  assign bus.syn_ready = syn_ready_r;
  assign bus.load      = load_r;
  assign bus.run       = run_r;
  assign bus.out_valid = out_valid_r;
  assign bus.err       = err_r;
  assign bus.iter_cnt  = iter_cnt_s;
  assign bus.swap_cnt  = swap_cnt_s;

endmodule

// File: tb/tb_euclid_ctrl.sv
// Directed self-checking bench for euclid_ctrl; expectations are hand-derived
// cycle counts and counter values for each job scenario.
module tb_euclid_ctrl;
  import euclid_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;

  euclid_ctrl_if bus_if ();

  euclid_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents syn_valid in IDLE; returns positioned in the first RUN cycle.
  task automatic start_job();
    bus_if.syn_valid = 1'b1;
    step();
    bus_if.syn_valid = 1'b0;
    check_eq("start_load", {31'd0, bus_if.load}, 32'd1);
    step();
    check_eq("start_run", {31'd0, bus_if.run}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus_if.syn_valid = 1'b1;
    bus_if.stop_i    = 1'b0;
    bus_if.sw_i      = 1'b0;
    bus_if.out_ready = 1'b0;

    // Reset held with syn_valid high.
    repeat (3) step();
    check_eq("rst_syn_ready", {31'd0, bus_if.syn_ready}, 32'd1);
    check_eq("rst_load",      {31'd0, bus_if.load},      32'd0);
    check_eq("rst_run",       {31'd0, bus_if.run},       32'd0);
    check_eq("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("rst_err",       {31'd0, bus_if.err},       32'd0);
    check_eq("rst_iter",      {27'd0, bus_if.iter_cnt},  32'd0);
    check_eq("rst_swap",      {27'd0, bus_if.swap_cnt},  32'd0);
    reset = 1'b1;
    step();
    check_eq("rel_load", {31'd0, bus_if.load}, 32'd1);
    bus_if.syn_valid = 1'b0;
    step();
    check_eq("rel_run", {31'd0, bus_if.run}, 32'd1);
    bus_if.stop_i = 1'b1;
    step();
    bus_if.stop_i = 1'b0;
    step();
    check_eq("rel_done_valid", {31'd0, bus_if.out_valid}, 32'd1);
    bus_if.out_ready = 1'b1;
    step();
    check_eq("rel_idle", {31'd0, bus_if.syn_ready}, 32'd1);

    // Seven iterations with swaps on three of them.
    start_job();
    for (int i = 0; i < 7; i++) begin
      bus_if.sw_i = (i == 1 || i == 3 || i == 6);
      step();
    end
    bus_if.stop_i = 1'b1;
    bus_if.sw_i   = 1'b1;
    step();
    bus_if.stop_i = 1'b0;
    bus_if.sw_i   = 1'b0;
    check_eq("a_drain_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("a_drain_run",   {31'd0, bus_if.run},       32'd0);
    step();
    check_eq("a_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("a_iter",  {27'd0, bus_if.iter_cnt},  32'd7);
    check_eq("a_swap",  {27'd0, bus_if.swap_cnt},  32'd3);
    check_eq("a_err",   {31'd0, bus_if.err},       32'd0);
    step();
    check_eq("a_valid_drop", {31'd0, bus_if.out_valid}, 32'd0);

    // Stop on the first RUN cycle; stop_i raised early is ignored in IDLE/LOAD.
    bus_if.syn_valid = 1'b1;
    bus_if.stop_i    = 1'b1;
    cyc = 0;
    step();
    bus_if.syn_valid = 1'b0;
    cyc = 1;
    while (!bus_if.out_valid && cyc < 12) begin
      step();
      cyc = cyc + 1;
    end
    bus_if.stop_i = 1'b0;
    check_eq("b_latency", cyc, 32'd4);
    check_eq("b_iter",    {27'd0, bus_if.iter_cnt}, 32'd0);
    check_eq("b_swap",    {27'd0, bus_if.swap_cnt}, 32'd0);
    step();
    check_eq("b_one_cycle_valid", {31'd0, bus_if.out_valid}, 32'd0);

    // Long run: watchdog behaviour depends on the build.
    bus_if.out_ready = 1'b0;
    start_job();
`ifdef EUCLID_CTRL_TIMEOUT_EN
    cyc = 0;
    while (!bus_if.out_valid && cyc < 60) begin
      step();
      cyc = cyc + 1;
    end
    check_eq("c_wd_cycles", cyc, 32'd18);
    check_eq("c_wd_iter",   {27'd0, bus_if.iter_cnt}, 32'd16);
    check_eq("c_wd_err",    {31'd0, bus_if.err},      32'd1);
`else
    repeat (40) step();
    check_eq("c_still_run",  {31'd0, bus_if.run},       32'd1);
    check_eq("c_no_valid",   {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("c_iter_sat",   {27'd0, bus_if.iter_cnt},  32'd31);
    bus_if.stop_i = 1'b1;
    step();
    bus_if.stop_i = 1'b0;
    step();
    check_eq("c_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("c_err",   {31'd0, bus_if.err},       32'd0);
`endif

    // Backpressure for five cycles with a pending job request.
    bus_if.syn_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("d_hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
      check_eq("d_hold_ready", {31'd0, bus_if.syn_ready}, 32'd0);
      check_eq("d_hold_load",  {31'd0, bus_if.load},      32'd0);
`ifdef EUCLID_CTRL_TIMEOUT_EN
      check_eq("d_hold_iter",  {27'd0, bus_if.iter_cnt},  32'd16);
`else
      check_eq("d_hold_iter",  {27'd0, bus_if.iter_cnt},  32'd31);
`endif
    end
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    check_eq("d_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("d_idle_ready", {31'd0, bus_if.syn_ready}, 32'd1);
    step();
    bus_if.syn_valid = 1'b0;
    check_eq("d_load", {31'd0, bus_if.load},     32'd1);
    check_eq("d_clr",  {27'd0, bus_if.iter_cnt}, 32'd0);
    check_eq("d_err_clr", {31'd0, bus_if.err},   32'd0);
    step();
    bus_if.sw_i = 1'b1;
    repeat (2) step();
    bus_if.sw_i   = 1'b0;
    bus_if.stop_i = 1'b1;
    step();
    bus_if.stop_i = 1'b0;
    step();
    check_eq("d_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("d_iter",  {27'd0, bus_if.iter_cnt},  32'd2);
    check_eq("d_swap",  {27'd0, bus_if.swap_cnt},  32'd2);
    bus_if.out_ready = 1'b1;
    step();

    // Reset in RUN at iter_cnt=4, then a clean job.
    start_job();
    bus_if.sw_i = 1'b1;
    repeat (4) step();
    bus_if.sw_i = 1'b0;
    check_eq("e_iter_pre", {27'd0, bus_if.iter_cnt}, 32'd4);
    reset = 1'b0;
    #1;
    check_eq("e_run",      {31'd0, bus_if.run},       32'd0);
    check_eq("e_iter",     {27'd0, bus_if.iter_cnt},  32'd0);
    check_eq("e_swap",     {27'd0, bus_if.swap_cnt},  32'd0);
    check_eq("e_ready",    {31'd0, bus_if.syn_ready}, 32'd1);
    repeat (2) step();
    check_eq("e_no_valid", {31'd0, bus_if.out_valid}, 32'd0);
    reset = 1'b1;
    step();
    check_eq("e_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
    start_job();
    for (int i = 0; i < 3; i++) begin
      bus_if.sw_i = (i == 2);
      step();
    end
    bus_if.sw_i   = 1'b0;
    bus_if.stop_i = 1'b1;
    step();
    bus_if.stop_i = 1'b0;
    step();
    check_eq("e_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check_eq("e_iter2", {27'd0, bus_if.iter_cnt},  32'd3);
    check_eq("e_swap2", {27'd0, bus_if.swap_cnt},  32'd1);
    check_eq("e_err2",  {31'd0, bus_if.err},       32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
